// File: rtl/conv_pkg.sv
// Shared constants and window packing helpers for the 5x5 convolution path.
// The window generator and the convolution stage both use win_bit_offset,
// so the bit layout of the window bus is defined in exactly one place.
package conv_pkg;

    localparam int unsigned KernelSizeDefault = 5;
    localparam int unsigned WinElems          = KernelSizeDefault * KernelSizeDefault;

    // LSB position of element (channel c, row r, col k) inside a packed window.
    // r = 0 is the top (oldest) row, k = 0 the leftmost (oldest) column.
    function automatic int unsigned win_bit_offset(input int unsigned bit_width,
                                                   input int unsigned kernel_size,
                                                   input int unsigned c,
                                                   input int unsigned r,
                                                   input int unsigned k);
        return bit_width * (c * kernel_size * kernel_size + r * kernel_size + k);
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image-row delay: a circular RAM addressed by a pointer that is shared
// between the read and write side. The word at ptr_i is the sample written
// exactly Depth enables ago; it is read out and overwritten in the same cycle.
module conv_line_buffer #(
    parameter int unsigned Width = 24,
    parameter int unsigned Depth = 32,
    parameter int unsigned PtrW  = 5
) (
    input  logic             clk_i,
    input  logic             en_i,
    input  logic [PtrW-1:0]  ptr_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o
);

    logic [Width-1:0] mem_q [Depth];

    assign data_o = mem_q[ptr_i];

    // Storage is deliberately not reset; downstream validity gating hides stale rows.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            mem_q[ptr_i] <= data_i;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming KERNEL_SIZE x KERNEL_SIZE x CHANNEL window generator feeding the
// convolution datapath. Pixels arrive in raster order; valid (no padding)
// windows with stride 1 are emitted one cycle after their bottom-right pixel.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int unsigned BIT_WIDTH   = 8,
    parameter int unsigned KERNEL_SIZE = KernelSizeDefault,
    parameter int unsigned CHANNEL     = 3,
    parameter int unsigned IMG_WIDTH   = 32,
    parameter int unsigned IMG_HEIGHT  = 32
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [BIT_WIDTH*CHANNEL-1:0]                      in_pixel,
    input  logic                                              in_valid,
    output logic                                              in_ready,
    output logic [BIT_WIDTH*KERNEL_SIZE*KERNEL_SIZE*CHANNEL-1:0] out_window,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic                                              out_last
);

    localparam int unsigned PixW = BIT_WIDTH * CHANNEL;
    localparam int unsigned WinW = BIT_WIDTH * KERNEL_SIZE * KERNEL_SIZE * CHANNEL;
    localparam int unsigned ColW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned RowW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [ColW-1:0] ColMax   = ColW'(IMG_WIDTH - 1);
    localparam logic [RowW-1:0] RowMax   = RowW'(IMG_HEIGHT - 1);
    localparam logic [ColW-1:0] ColFirst = ColW'(KERNEL_SIZE - 1);
    localparam logic [RowW-1:0] RowFirst = RowW'(KERNEL_SIZE - 1);

    logic            accept;
    logic            emit;
    logic            frame_end;

    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;

    logic [PixW-1:0] lb_out [KERNEL_SIZE-1];

    logic [PixW-1:0] win_q    [KERNEL_SIZE][KERNEL_SIZE];
    logic [PixW-1:0] win_next [KERNEL_SIZE][KERNEL_SIZE];
    logic [WinW-1:0] win_packed;

    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic [WinW-1:0] out_window_q, out_window_d;

    // A held window blocks input so the window array never moves under it.
    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign frame_end = (col_q == ColMax) && (row_q == RowMax);
    assign emit      = accept && (row_q >= RowFirst) && (col_q >= ColFirst);

    // Raster position of the next pixel to be accepted.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == ColMax) begin
                col_d = '0;
                row_d = (row_q == RowMax) ? '0 : row_q + RowW'(1);
            end else begin
                col_d = col_q + ColW'(1);
            end
        end
    end

    // Chain of row delays; buffer 0 holds the previous row, the last one the oldest.
    for (genvar i = 0; i < KERNEL_SIZE - 1; i++) begin : g_lb
        logic [PixW-1:0] lb_in;
        if (i == 0) begin : g_head
            assign lb_in = in_pixel;
        end else begin : g_chain
            assign lb_in = lb_out[i-1];
        end

        conv_line_buffer #(
            .Width (PixW),
            .Depth (IMG_WIDTH),
            .PtrW  (ColW)
        ) u_line_buffer (
            .clk_i  (clk),
            .en_i   (accept),
            .ptr_i  (col_q),
            .data_i (lb_in),
            .data_o (lb_out[i])
        );
    end

    // Next window: shift every row left, load the new right-hand column.
    always_comb begin
        win_next = win_q;
        for (int r = 0; r < KERNEL_SIZE; r++) begin
            for (int k = 0; k < KERNEL_SIZE - 1; k++) begin
                win_next[r][k] = win_q[r][k+1];
            end
        end
        for (int r = 0; r < KERNEL_SIZE - 1; r++) begin
            win_next[r][KERNEL_SIZE-1] = lb_out[KERNEL_SIZE-2-r];
        end
        win_next[KERNEL_SIZE-1][KERNEL_SIZE-1] = in_pixel;
    end

    // Flatten the next window into the convolution's input_feature layout.
    always_comb begin
        win_packed = '0;
        for (int c = 0; c < CHANNEL; c++) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int k = 0; k < KERNEL_SIZE; k++) begin
                    win_packed[win_bit_offset(BIT_WIDTH, KERNEL_SIZE, c, r, k) +: BIT_WIDTH] =
                        win_next[r][k][c*BIT_WIDTH +: BIT_WIDTH];
                end
            end
        end
    end

    // Output register: load on emit, drop on drain, otherwise hold.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_window_d = out_window_q;
        if (emit) begin
            out_valid_d  = 1'b1;
            out_last_d   = frame_end;
            out_window_d = win_packed;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    // Window shift array advances on every accepted pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int k = 0; k < KERNEL_SIZE; k++) begin
                    win_q[r][k] <= '0;
                end
            end
        end else if (accept) begin
            win_q <= win_next;
        end
    end

    // Position counters and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_window_q <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_window_q <= out_window_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_window = out_window_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on an 8x6, 3-channel image.
// Channel c sample of pixel (row, col) is (c << 6) | (row * 8 + col).
module tb_conv_window_gen;

    localparam int BW   = 8;
    localparam int KS   = 5;
    localparam int CH   = 3;
    localparam int IW   = 8;
    localparam int IH   = 6;
    localparam int PixW = BW * CH;
    localparam int WinW = BW * KS * KS * CH;
    localparam int FramePix = IW * IH;
    localparam int FrameWin = (IW - KS + 1) * (IH - KS + 1);

    logic            clk;
    logic            rst;
    logic [PixW-1:0] in_pixel;
    logic            in_valid;
    logic            in_ready;
    logic [WinW-1:0] out_window;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;

    int n_cmp;
    int n_err;
    int pix_idx;
    int first_valid_idx;

    logic [WinW-1:0] cap_win [$];
    logic            cap_last [$];

    conv_window_gen #(
        .BIT_WIDTH   (BW),
        .KERNEL_SIZE (KS),
        .CHANNEL     (CH),
        .IMG_WIDTH   (IW),
        .IMG_HEIGHT  (IH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_pixel   (in_pixel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_window (out_window),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every window transfer (handshake happens at the following rising edge).
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            cap_win.push_back(out_window);
            cap_last.push_back(out_last);
        end
    end

    // Pixel number idx of the stream; row*8+col equals the in-frame index.
    function automatic logic [PixW-1:0] pix(input int idx);
        logic [PixW-1:0] px;
        int p;
        p = idx % FramePix;
        for (int c = 0; c < CH; c++) begin
            px[c*BW +: BW] = 8'((c << 6) | p);
        end
        return px;
    endfunction

    // Golden window w of a frame (windows numbered in raster order of top-left corner).
    function automatic logic [WinW-1:0] exp_window(input int w);
        logic [WinW-1:0] ew;
        int wr;
        int wc;
        wr = w / (IW - KS + 1);
        wc = w % (IW - KS + 1);
        ew = '0;
        for (int c = 0; c < CH; c++) begin
            for (int r = 0; r < KS; r++) begin
                for (int k = 0; k < KS; k++) begin
                    ew[BW*(c*KS*KS + r*KS + k) +: BW] = 8'((c << 6) | ((wr + r) * IW + wc + k));
                end
            end
        end
        return ew;
    endfunction

    task automatic do_reset();
        in_valid  = 1'b0;
        in_pixel  = '0;
        out_ready = 1'b1;
        rst       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cap_win.delete();
        cap_last.delete();
        pix_idx         = 0;
        first_valid_idx = -1;
    endtask

    // Present n more pixels; optional input bubbles and random output stalls.
    // Entered and left just after a rising edge.
    task automatic feed(input int n, input bit bubbles, input bit bp, output bit timed_out);
        int done;
        int cyc;
        int last_acc;
        done      = 0;
        cyc       = 0;
        timed_out = 1'b0;
        while (done < n) begin
            if (cyc >= n * 8 + 64) begin
                timed_out = 1'b1;
                break;
            end
            in_valid  = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            in_pixel  = pix(pix_idx);
            out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            last_acc = -1;
            if (in_valid && in_ready) begin
                last_acc = pix_idx;
                pix_idx++;
                done++;
            end
            @(posedge clk);
            #1;
            if (out_valid && first_valid_idx < 0) first_valid_idx = last_acc;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid);
        end
        n_cmp++;
        if (out_last !== 1'b0) begin
            n_err++; $display("FAIL reset_out_last: got %b, expected 0", out_last);
        end
        n_cmp++;
        if (out_window !== '0) begin
            n_err++; $display("FAIL reset_out_window: got %0h, expected 0", out_window);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
        end
    endtask

    task automatic test_basic();
        bit to;
        logic [WinW-1:0] w;
        int n_last;
        do_reset();
        feed(FramePix, 1'b0, 1'b0, to);
        drain();
        n_cmp++;
        if (to) begin
            n_err++; $display("FAIL basic_timeout: got timeout, expected frame fed");
        end
        n_cmp++;
        if (first_valid_idx !== 36) begin
            n_err++; $display("FAIL basic_first_valid: got pixel %0d, expected 36", first_valid_idx);
        end
        n_cmp++;
        if (cap_win.size() !== FrameWin) begin
            n_err++; $display("FAIL basic_count: got %0d, expected %0d", cap_win.size(), FrameWin);
        end
        n_last = 0;
        for (int i = 0; i < cap_win.size() && i < FrameWin; i++) begin
            n_cmp++;
            if (cap_win[i] !== exp_window(i)) begin
                n_err++; $display("FAIL basic_window%0d: got %0h, expected %0h", i, cap_win[i], exp_window(i));
            end
            n_cmp++;
            if (cap_last[i] !== (i == FrameWin - 1)) begin
                n_err++; $display("FAIL basic_last%0d: got %b, expected %b", i, cap_last[i], i == FrameWin - 1);
            end
            if (cap_last[i]) n_last++;
        end
        n_cmp++;
        if (n_last !== 1) begin
            n_err++; $display("FAIL basic_last_count: got %0d, expected 1", n_last);
        end
        if (cap_win.size() >= FrameWin) begin
            w = cap_win[0];
            n_cmp++;
            if (w[0 +: 8] !== 8'h00) begin
                n_err++; $display("FAIL basic_e00: got %0h, expected 00", w[0 +: 8]);
            end
            n_cmp++;
            if (w[32 +: 8] !== 8'h04) begin
                n_err++; $display("FAIL basic_e04: got %0h, expected 04", w[32 +: 8]);
            end
            n_cmp++;
            if (w[160 +: 8] !== 8'h20) begin
                n_err++; $display("FAIL basic_e40: got %0h, expected 20", w[160 +: 8]);
            end
            n_cmp++;
            if (w[192 +: 8] !== 8'h24) begin
                n_err++; $display("FAIL basic_e44: got %0h, expected 24", w[192 +: 8]);
            end
            w = cap_win[FrameWin-1];
            n_cmp++;
            if (w[192 +: 8] !== 8'h2F) begin
                n_err++; $display("FAIL basic_last_e44: got %0h, expected 2F", w[192 +: 8]);
            end
        end
    endtask

    task automatic test_channel_packing();
        bit to;
        logic [WinW-1:0] w;
        do_reset();
        feed(FramePix, 1'b0, 1'b0, to);
        drain();
        n_cmp++;
        if (cap_win.size() !== FrameWin) begin
            n_err++; $display("FAIL pack_count: got %0d, expected %0d", cap_win.size(), FrameWin);
        end
        if (cap_win.size() >= FrameWin) begin
            w = cap_win[0];
            n_cmp++;
            if (w[592 +: 8] !== 8'hA4) begin
                n_err++; $display("FAIL pack_c2_e44: got %0h, expected A4", w[592 +: 8]);
            end
            n_cmp++;
            if (w[200 +: 8] !== 8'h40) begin
                n_err++; $display("FAIL pack_c1_e00: got %0h, expected 40", w[200 +: 8]);
            end
            n_cmp++;
            if (w[400 +: 8] !== 8'h80) begin
                n_err++; $display("FAIL pack_c2_e00: got %0h, expected 80", w[400 +: 8]);
            end
            w = cap_win[FrameWin-1];
            n_cmp++;
            if (w[392 +: 8] !== 8'h6F) begin
                n_err++; $display("FAIL pack_last_c1_e44: got %0h, expected 6F", w[392 +: 8]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        logic [WinW-1:0] w_hold;
        do_reset();
        feed(37, 1'b0, 1'b0, to);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pixel  = pix(pix_idx);
        w_hold    = out_window;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_err++; $display("FAIL bp_in_ready%0d: got %b, expected 0", i, in_ready);
            end
            n_cmp++;
            if (out_valid !== 1'b1) begin
                n_err++; $display("FAIL bp_out_valid%0d: got %b, expected 1", i, out_valid);
            end
            n_cmp++;
            if (out_window !== w_hold || w_hold !== exp_window(0)) begin
                n_err++; $display("FAIL bp_hold%0d: got %0h, expected %0h", i, out_window, exp_window(0));
            end
            @(posedge clk);
            #1;
        end
        feed(FramePix - 37, 1'b0, 1'b1, to);
        drain();
        n_cmp++;
        if (to) begin
            n_err++; $display("FAIL bp_timeout: got timeout, expected frame fed");
        end
        n_cmp++;
        if (cap_win.size() !== FrameWin) begin
            n_err++; $display("FAIL bp_count: got %0d, expected %0d", cap_win.size(), FrameWin);
        end
        for (int i = 0; i < cap_win.size() && i < FrameWin; i++) begin
            n_cmp++;
            if (cap_win[i] !== exp_window(i) || cap_last[i] !== (i == FrameWin - 1)) begin
                n_err++; $display("FAIL bp_window%0d: got %0h last %b, expected %0h last %b",
                                  i, cap_win[i], cap_last[i], exp_window(i), i == FrameWin - 1);
            end
        end
    endtask

    task automatic test_bubbles();
        bit to;
        do_reset();
        feed(FramePix, 1'b1, 1'b0, to);
        drain();
        n_cmp++;
        if (to) begin
            n_err++; $display("FAIL bub_timeout: got timeout, expected frame fed");
        end
        n_cmp++;
        if (cap_win.size() !== FrameWin) begin
            n_err++; $display("FAIL bub_count: got %0d, expected %0d", cap_win.size(), FrameWin);
        end
        for (int i = 0; i < cap_win.size() && i < FrameWin; i++) begin
            n_cmp++;
            if (cap_win[i] !== exp_window(i) || cap_last[i] !== (i == FrameWin - 1)) begin
                n_err++; $display("FAIL bub_window%0d: got %0h last %b, expected %0h last %b",
                                  i, cap_win[i], cap_last[i], exp_window(i), i == FrameWin - 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        int n_last;
        do_reset();
        feed(2 * FramePix, 1'b0, 1'b0, to);
        drain();
        n_cmp++;
        if (cap_win.size() !== 2 * FrameWin) begin
            n_err++; $display("FAIL b2b_count: got %0d, expected %0d", cap_win.size(), 2 * FrameWin);
        end
        n_last = 0;
        for (int i = 0; i < cap_win.size() && i < 2 * FrameWin; i++) begin
            n_cmp++;
            if (cap_win[i] !== exp_window(i % FrameWin) ||
                cap_last[i] !== ((i % FrameWin) == FrameWin - 1)) begin
                n_err++; $display("FAIL b2b_window%0d: got %0h last %b, expected %0h last %b",
                                  i, cap_win[i], cap_last[i], exp_window(i % FrameWin),
                                  (i % FrameWin) == FrameWin - 1);
            end
            if (cap_last[i]) n_last++;
        end
        n_cmp++;
        if (n_last !== 2) begin
            n_err++; $display("FAIL b2b_last_count: got %0d, expected 2", n_last);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit to;
        do_reset();
        // Stop after pixel 37 so a window is pending when reset hits.
        feed(38, 1'b0, 1'b0, to);
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++; $display("FAIL mid_pending: got %b, expected 1", out_valid);
        end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL mid_async_valid: got %b, expected 0", out_valid);
        end
        n_cmp++;
        if (out_window !== '0 || out_last !== 1'b0) begin
            n_err++; $display("FAIL mid_async_out: got %0h last %b, expected 0 last 0", out_window, out_last);
        end
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        cap_win.delete();
        cap_last.delete();
        pix_idx         = 0;
        first_valid_idx = -1;
        feed(FramePix, 1'b0, 1'b0, to);
        drain();
        n_cmp++;
        if (first_valid_idx !== 36) begin
            n_err++; $display("FAIL mid_first_valid: got pixel %0d, expected 36", first_valid_idx);
        end
        n_cmp++;
        if (cap_win.size() !== FrameWin) begin
            n_err++; $display("FAIL mid_count: got %0d, expected %0d", cap_win.size(), FrameWin);
        end
        for (int i = 0; i < cap_win.size() && i < FrameWin; i++) begin
            n_cmp++;
            if (cap_win[i] !== exp_window(i) || cap_last[i] !== (i == FrameWin - 1)) begin
                n_err++; $display("FAIL mid_window%0d: got %0h last %b, expected %0h last %b",
                                  i, cap_win[i], cap_last[i], exp_window(i), i == FrameWin - 1);
            end
        end
    endtask

    initial begin
        n_cmp           = 0;
        n_err           = 0;
        pix_idx         = 0;
        first_valid_idx = -1;
        rst             = 1'b0;
        in_valid        = 1'b0;
        in_pixel        = '0;
        out_ready       = 1'b1;
        test_reset();
        test_basic();
        test_channel_packing();
        test_backpressure();
        test_bubbles();
        test_back_to_back();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Streaming window generator that sits directly upstream of the multi-channel 5x5 convolution datapath.
- Accepts one multi-channel pixel per handshake in raster order.
- Buffers KERNEL_SIZE-1 image rows and emits each complete KERNEL_SIZE x KERNEL_SIZE x CHANNEL window, packed exactly as the convolution's input_feature bus expects.
- Valid (no-padding) convolution, stride 1.

Parameters:
- BIT_WIDTH, 8, bits per pixel sample per channel
- KERNEL_SIZE, 5, window height and width
- CHANNEL, 3, channels per pixel
- IMG_WIDTH, 32, pixels per row; must be >= KERNEL_SIZE
- IMG_HEIGHT, 32, rows per frame; must be >= KERNEL_SIZE

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- in_pixel  in  BIT_WIDTH*CHANNEL  one pixel; channel c at bits [BIT_WIDTH*(c+1)-1 : BIT_WIDTH*c]
- in_valid  in  1  in_pixel is valid
- in_ready  out  1  block accepts in_pixel this cycle
- out_window  out  BIT_WIDTH*KERNEL_SIZE*KERNEL_SIZE*CHANNEL  packed window feeding the convolution's input_feature
- out_valid  out  1  out_window holds a valid window
- out_ready  in  1  consumer takes out_window this cycle
- out_last  out  1  qualifies out_valid; marks the last window of the frame

Behaviour:
- Accept: in_valid && in_ready. in_ready = !out_valid || out_ready (combinational). No pixel is lost or duplicated under backpressure.
- Counters:
  - col in 0..IMG_WIDTH-1 and row in 0..IMG_HEIGHT-1 name the position of the next accepted pixel.
  - On accept, col increments; at IMG_WIDTH-1 it wraps to 0 and row increments.
  - At (IMG_WIDTH-1, IMG_HEIGHT-1) both wrap to 0, and the next frame starts with no idle cycle.
- Line buffers:
  - KERNEL_SIZE-1 row delays, each IMG_WIDTH deep, CHANNEL*BIT_WIDTH wide, chained.
  - They advance only on accept.
  - Contents are not cleared between frames; stale data is never emitted because of the validity gating below.
- Window register:
  - KERNEL_SIZE x KERNEL_SIZE shift array. On accept, every row shifts left by one column.
  - Column KERNEL_SIZE-1 loads the current pixel (bottom row r=KERNEL_SIZE-1) and the line-buffer outputs (upper rows, r=0 oldest).
- Output:
  - A window is emitted when the accepted pixel has row >= KERNEL_SIZE-1 and col >= KERNEL_SIZE-1.
  - On that accept, out_window and out_valid are registered: latency 1 cycle after the accepting edge.
  - out_valid clears on out_ready when no new window is loaded in the same cycle. Load and drain in the same cycle leaves out_valid = 1 with the new window.
  - out_window and out_last are held stable while out_valid && !out_ready.
  - Windows per frame = (IMG_WIDTH-KERNEL_SIZE+1)*(IMG_HEIGHT-KERNEL_SIZE+1).
  - out_last = 1 only on the window whose accepting pixel is (IMG_WIDTH-1, IMG_HEIGHT-1).
- Packing:
  - Element (channel c, row r, col k), with r=0 top/oldest and k=0 leftmost/oldest.
  - It occupies bits starting at BIT_WIDTH*(c*KERNEL_SIZE*KERNEL_SIZE + r*KERNEL_SIZE + k).
- Reset (asynchronous, rst low):
  - out_valid=0, out_last=0, out_window=0, col=row=0, window registers = 0.
  - Line-buffer storage is not required to reset.
  - A reset mid-frame aborts the frame; the next accepted pixel is (0,0).
- No arithmetic; pure data movement. No X on outputs after reset.

Decomposition:
- Shared package conv_pkg:
  - KERNEL_SIZE default
  - window element count KERNEL_SIZE*KERNEL_SIZE
  - a function returning the bit offset for (c, r, k)
  - Used by this block and the convolution stage so packing cannot diverge.
- One sub-module, conv_line_buffer:
  - A single row delay of depth IMG_WIDTH with a shift enable, built as a circular RAM with a shared pointer.
  - Instantiated KERNEL_SIZE-1 times.

Test Plan:
- Basic frame: IMG_WIDTH=8, IMG_HEIGHT=6, CHANNEL=1, pixel = row*16+col, out_ready=1, in_valid=1 continuously.
  - First out_valid one cycle after accepting pixel index 36 (row 4, col 4).
  - Window element (0,0)=0x00, (0,4)=0x04, (4,0)=0x40, (4,4)=0x44.
  - Exactly 8 windows; out_last only on the 8th, which has (4,4)=0x57.
- Channel packing: CHANNEL=3, channel c sample = (c<<6)|(row*8+col) with 6-bit position.
  - First window channel 2 element (4,4) = 0xA4, located at bit offset 8*(2*25+24)=592.
- Backpressure: hold out_ready=0 for 3 cycles while a window is valid.
  - in_ready=0 and out_window stable throughout.
  - After release, the full window sequence still matches the golden model with no gaps or duplicates.
- Input bubbles: random in_valid duty of 50%.
  - Window contents and count are identical to the continuous case.
- Back-to-back frames: two frames with no gap.
  - The second frame's first window appears only after its pixel (4,4), with no windows spanning frames.
  - out_last is asserted exactly twice.
- Reset mid-frame: assert rst low after 20 pixels.
  - out_valid=0 immediately (asynchronous).
  - A following full frame produces the exact basic-frame output.
